pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder/subtractor. It succeeds the fixed 4-bit combinational ripple-carry adder. The WIDTH-bit operation is split into STAGES equal chunks, one chunk per pipeline stage, with the carry registered between stages. This gives one result per cycle at any width. The block sits on datapaths behind a valid/ready stream and provides full throughput with backpressure.

## Interface
Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; each stage adds one chunk of CHUNK = WIDTH/STAGES bits; 1 ≤ STAGES ≤ WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned/two's complement.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry in (sub=0) or borrow in (sub=1).
- sub  input  1  0: a+b+carry_in; 1: a−b−carry_in.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- carry_out  output  1  raw carry out of the MSB; for sub=1, 1 = no borrow.

## Operation
- Effective operands: b_eff = sub ? ~b : b; c0 = sub ? ~carry_in : carry_in; result = a + b_eff + c0.
- Stage k (0..STAGES−1) adds chunk k (bits k·CHUNK+CHUNK−1 : k·CHUNK) of a and b_eff plus the carry registered from stage k−1. Stage 0 uses c0.
- Upper-chunk operands travel in skew registers until their stage. Lower-chunk sums travel alongside until output (deskew). Every stage holds one transaction.
- Each stage has a valid bit. A bubble is a stage with valid=0.
- Global advance: adv = !out_valid || out_ready. When adv=1, all stages shift one place, and stage 0 loads the input if in_valid, otherwise a bubble.
- in_ready = adv, combinational from out_valid/out_ready. There is no path from in_valid to in_ready.
- Transfers occur on in_valid&&in_ready and on out_valid&&out_ready.
- When adv=0, all stage registers hold. sum, carry_out and out_valid stay stable until accepted.
- No state machine beyond the valid shift chain. Arithmetic is exact modulo 2^WIDTH, and carry_out is the true carry out of the WIDTH-bit add.

## Timing
- Reset, asynchronous on rst_n low, all outputs and state immediately:
  - out_valid=0, sum=0, carry_out=0 (and overflow=0 if configured);
  - all valid bits 0, all stage and skew registers 0;
  - in_ready therefore 1.
- Latency: an accepted transaction appears at the outputs STAGES cycles after the accepting edge when not stalled.
- Throughput: 1 transaction/cycle while out_ready=1.
- Full pipeline plus out_ready=0: in_ready=0. No transaction is lost or duplicated.
- Simultaneous output accept and input accept in the same cycle is legal and keeps full throughput.
- Bubbles are not collapsed. A stall freezes the whole pipeline, bubbles included.
- Reset mid-operation: all in-flight transactions are discarded. After rst_n rises, only post-reset inputs produce results.
- Input operands are sampled only on the accepting edge. They may change freely otherwise.

## Configuration
- PIPELINED_ADDER_OVERFLOW_EN defined:
  - adds output port `overflow` (1 bit), the signed two's-complement overflow of the operation;
  - overflow = carry into MSB XOR carry out of MSB, using b_eff and c0;
  - aligned with sum; reset value 0.
- Macro undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package adder_pkg:
  - default WIDTH/STAGES constants;
  - a stage-record typedef (valid, carry, partial sum) generic over CHUNK via parameters in the module.
- Sub-module adder_chunk: combinational CHUNK-bit ripple adder with ports a, b, cin, sum, cout, and MSB-carry-in for the overflow path. It is instantiated STAGES times in a generate loop.
- pipelined_adder holds all registers, skew/deskew and handshake logic.

## Test plan
Defaults: WIDTH=16, STAGES=4.
- Full ripple: a=0xFFFF, b=0x0001, carry_in=0, sub=0, out_ready=1 → after 4 cycles sum=0x0000, carry_out=1.
- Subtract: a=0x0005, b=0x0007, carry_in=0, sub=1 → sum=0xFFFE, carry_out=0; with carry_in=1 → sum=0xFFFD.
- Streaming: 8 back-to-back random transactions with out_ready=1 → 8 results on consecutive cycles, first at cycle 4, all matching the reference model; in_ready stays 1.
- Backpressure: fill the pipeline, hold out_ready=0 for 3 cycles → in_ready=0, sum/carry_out/out_valid frozen; after release, results arrive in order with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 with 3 transactions in flight → out_valid=0 and sum=0 immediately; after release, the first result equals the first post-reset input.
- Overflow (macro on): a=0x7FFF, b=0x0001, sub=0 → overflow=1; a=0x8000, b=0x0001, sub=1 → overflow=1; a=0x0001, b=0x0001 → overflow=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and stage-record types for the pipelined adder family.
package adder_pkg;

  localparam int unsigned DEFAULT_WIDTH  = 16;
  localparam int unsigned DEFAULT_STAGES = 4;

  // Control half of a pipeline stage record; the data half is sized per instance.
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_ctl_t;

  function automatic int unsigned chunk_width(input int unsigned width, input int unsigned stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice; also exposes the carry into its MSB.
module adder_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  logic [CHUNK:0] c;

  // Bit-serial ripple through the chunk
  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor with valid/ready stream handshake.
// Optional signed overflow output enabled by PIPELINED_ADDER_OVERFLOW_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned CHUNK = chunk_width(WIDTH, STAGES);

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Whole pipeline advances together; a stall freezes bubbles as well
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~carry_in : carry_in;

  // Stage k register holds the operands/carry entering chunk k.
  // acc carries finished sum bits below chunk k and raw A bits from chunk k up;
  // bsk carries only the not-yet-consumed upper bits of b_eff.
  for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
    localparam int unsigned BW = WIDTH - (int'(k) * CHUNK);

    stage_ctl_t       ctl;
    logic [WIDTH-1:0] acc;
    logic [BW-1:0]    bsk;
    logic [CHUNK-1:0] csum;
    logic             cout;
    logic             msb_cin;
    logic             unused_msb_cin;
    logic [WIDTH-1:0] acc_nxt;

    adder_chunk #(
      .CHUNK (CHUNK)
    ) u_chunk (
      .a       (acc[k*CHUNK +: CHUNK]),
      .b       (bsk[CHUNK-1:0]),
      .cin     (ctl.carry),
      .sum     (csum),
      .cout    (cout),
      .msb_cin (msb_cin)
    );

    assign unused_msb_cin = msb_cin;

    always_comb begin
      acc_nxt                     = acc;
      acc_nxt[k*CHUNK +: CHUNK]   = csum;
    end

    if (k == 0) begin : g_load
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctl <= '0;
          acc <= '0;
          bsk <= '0;
        end else if (adv) begin
          ctl.valid <= in_valid;
          ctl.carry <= c0;
          acc       <= a;
          bsk       <= b_eff;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctl <= '0;
          acc <= '0;
          bsk <= '0;
        end else if (adv) begin
          ctl.valid <= g_stage[k-1].ctl.valid;
          ctl.carry <= g_stage[k-1].cout;
          acc       <= g_stage[k-1].acc_nxt;
          bsk       <= g_stage[k-1].bsk[BW+CHUNK-1:CHUNK];
        end
      end
    end
  end

  // Output register: result of the final chunk, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= g_stage[STAGES-1].ctl.valid;
      sum       <= g_stage[STAGES-1].acc_nxt;
      carry_out <= g_stage[STAGES-1].cout;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
      overflow  <= g_stage[STAGES-1].msb_cin ^ g_stage[STAGES-1].cout;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomized scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4).
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int ST = 4;
  localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (W - 1));

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         carry_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef PIPELINED_ADDER_OVERFLOW_EN
  logic         overflow;
`endif

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  exp_t sb[$];
  bit   no_stall;
  bit   stalled;
  logic [W-1:0] held_sum;
  logic         held_cout;

  pipelined_adder #(
    .WIDTH  (W),
    .STAGES (ST)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef PIPELINED_ADDER_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Reference: plain integer arithmetic on the effective operands
  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ici, input logic isub, input int c);
    exp_t   r;
    logic [W-1:0] bx;
    longint cin_i;
    longint u;
    longint s;
    bx    = isub ? ~ib : ib;
    cin_i = ((isub ? !ici : ici) == 1'b1) ? 1 : 0;
    u     = longint'(ia) + longint'(bx) + cin_i;
    s     = longint'($signed(ia)) + longint'($signed(bx)) + cin_i;
    r.sum  = W'(u);
    r.cout = (u >= (longint'(1) << W));
    r.ovf  = (s > SMAX) || (s < SMIN);
    r.cyc  = c;
    return r;
  endfunction

  // One cycle: drive at negedge, score the transfer about to happen at posedge
  task automatic step(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic ici, input logic isub, input logic ordy);
    exp_t e;
    @(negedge clk);
    if (stalled) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(held_sum));
      chk("hold_cout", 32'(carry_out), 32'(held_cout));
    end
    in_valid  = iv;
    a         = ia;
    b         = ib;
    carry_in  = ici;
    sub       = isub;
    out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        e = sb.pop_front();
        chk("sum", 32'(sum), 32'(e.sum));
        chk("carry_out", 32'(carry_out), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        chk("overflow", 32'(overflow), 32'(e.ovf));
`endif
        if (no_stall) chk("latency", 32'(cyc - e.cyc), 32'(ST + 1));
      end
    end
    stalled   = out_valid && !out_ready;
    held_sum  = sum;
    held_cout = carry_out;
    if (in_valid && in_ready) sb.push_back(model(a, b, carry_in, sub, cyc));
  endtask

  task automatic idle_step();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      idle_step();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    repeat (ST + 2) idle_step();
  endtask

  task automatic directed(input string tag, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic ici, input logic isub, input logic [W-1:0] exp_sum,
                          input logic exp_cout, input logic exp_ovf);
    bit seen = 0;
    no_stall = 1;
    step(1'b1, ia, ib, ici, isub, 1'b1);
    for (int k = 1; k <= 12 && !seen; k++) begin
      idle_step();
      if (out_valid) begin
        seen = 1;
        chk({tag, "_lat"}, 32'(k), 32'(ST + 1));
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(carry_out), 32'(exp_cout));
`ifdef PIPELINED_ADDER_OVERFLOW_EN
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
`endif
      end
    end
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    drain({tag, "_drain"});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0; out_ready = 1'b0;
    no_stall = 1; stalled = 0; held_sum = '0; held_cout = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(carry_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    directed("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("sub",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_bi", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
    directed("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("no_ovf", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    // Streaming: 8 back-to-back, full throughput
    no_stall = 1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
    end
    drain("stream_drain");

    // Backpressure: fill with out_ready low, hold, then release
    no_stall = 0;
    for (int i = 0; i < 8; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    drain("bp_drain");

    // Reset with transactions in flight
    no_stall = 1;
    for (int i = 0; i < 5; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(carry_out), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    stalled = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    drain("post_rst_drain");

    // Random traffic with random backpressure
    no_stall = 0;
    for (int i = 0; i < 300; i++)
      step(1'($urandom), W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
